// File: rtl/profile_counter_bank_ci_pkg.sv
// rtl/profile_counter_bank_ci_pkg.sv - shared field positions and status-word layout for the profiling counter bank
package profile_ci_pkg;

    localparam int MAX_COUNTERS = 8;

    // Control command fields carried on valueB
    localparam int B_ENABLE_LSB  = 0;
    localparam int B_DISABLE_LSB = 8;
    localparam int B_CLEAR_LSB   = 16;
    localparam int B_SNAPSHOT    = 24;
    localparam int B_CLEAR_OVF   = 25;

    // Read select fields carried on valueA
    localparam int A_INDEX_LSB  = 0;
    localparam int A_INDEX_BITS = 3;
    localparam int A_HIGH_WORD  = 3;
    localparam int A_SNAPSHOT   = 4;
    localparam int A_STATUS     = 5;

    typedef struct packed {
        logic [15:0] reserved;
        logic [7:0]  ovf;
        logic [7:0]  enable;
    } statusWord_t;

    function automatic logic [31:0] packStatus(input logic [7:0] ovf, input logic [7:0] enable);
        statusWord_t s;
        s.reserved = '0;
        s.ovf      = ovf;
        s.enable   = enable;
        return s;
    endfunction

endpackage

// File: rtl/profile_counter_bank_ci_if.sv
// rtl/profile_counter_bank_ci_if.sv - custom-instruction command/response bundle
interface profile_counter_bank_ci_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    modport master (output start, output ciN, output valueA, output valueB,
                    input done, input result);
    modport slave  (input start, input ciN, input valueA, input valueB,
                    output done, output result);
endinterface

// File: rtl/profile_counter_bank_ci_event_counter.sv
// rtl/profile_counter_bank_ci_event_counter.sv - one profiling counter with enable, clear, sticky overflow and snapshot
module profile_event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enableCmd,
    input  logic             disableCmd,
    input  logic             clearCmd,
    input  logic             snapshotCmd,
    input  logic             clearOvfCmd,
    input  logic             eventIn,
    output logic             enabled,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] snapshot,
    output logic             overflow
);

    logic bump;
    logic wrap;

    // A clear in the same command wins over counting, so a cleared counter starts at zero
    assign bump = enabled && eventIn && !clearCmd;
    assign wrap = bump && (count == {WIDTH{1'b1}});

    // Enable state; disable has priority over enable for the same counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enabled <= 1'b0;
        end else if (disableCmd) begin
            enabled <= 1'b0;
        end else if (enableCmd) begin
            enabled <= 1'b1;
        end
    end

    // Live count, uses the pre-command enable so a newly enabled counter skips its command cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clearCmd) begin
            count <= '0;
        end else if (bump) begin
            count <= count + WIDTH'(1);
        end
    end

    // Sticky overflow; a wrap on the same edge as a flag clear leaves the flag set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wrap) begin
            overflow <= 1'b1;
        end else if (clearCmd || clearOvfCmd) begin
            overflow <= 1'b0;
        end
    end

    // Snapshot copies the pre-edge live value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
        end else if (snapshotCmd) begin
            snapshot <= count;
        end
    end

endmodule

// File: rtl/profile_counter_bank_ci.sv
// rtl/profile_counter_bank_ci.sv - profiling counter bank behind an OpenRISC custom instruction
module profile_counter_bank_ci #(
    parameter logic [7:0] CUSTOM_ID     = 8'h00,
    parameter int         NUM_COUNTERS  = 4,
    parameter int         COUNTER_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_COUNTERS-1:0] events,
    profile_counter_bank_ci_if.slave bus
);
    import profile_ci_pkg::*;

    logic                          accept;
    logic [63:0]                   liveWide [MAX_COUNTERS];
    logic [63:0]                   snapWide [MAX_COUNTERS];
    logic [MAX_COUNTERS-1:0]       enableVec;
    logic [MAX_COUNTERS-1:0]       ovfVec;
    logic [A_INDEX_BITS-1:0]       readIndex;
    logic [63:0]                   picked;
    logic [31:0]                   readData;
    logic                          unusedBits;

    assign accept    = bus.start && (bus.ciN == CUSTOM_ID);
    assign readIndex = bus.valueA[A_INDEX_LSB +: A_INDEX_BITS];

    // Reserved select/command bits and control bits of absent counters have no effect
    assign unusedBits = ^{bus.valueA[31:6], bus.valueB};

    for (genvar i = 0; i < MAX_COUNTERS; i++) begin : gCtr
        if (i < NUM_COUNTERS) begin : gLive
            logic [COUNTER_WIDTH-1:0] liveCount;
            logic [COUNTER_WIDTH-1:0] snapCount;
            logic                     enabled;
            logic                     overflow;

            profile_event_counter #(
                .WIDTH(COUNTER_WIDTH)
            ) uCounter (
                .clock       (clock),
                .reset       (reset),
                .enableCmd   (accept && bus.valueB[B_ENABLE_LSB + i]),
                .disableCmd  (accept && bus.valueB[B_DISABLE_LSB + i]),
                .clearCmd    (accept && bus.valueB[B_CLEAR_LSB + i]),
                .snapshotCmd (accept && bus.valueB[B_SNAPSHOT]),
                .clearOvfCmd (accept && bus.valueB[B_CLEAR_OVF]),
                .eventIn     (events[i]),
                .enabled     (enabled),
                .count       (liveCount),
                .snapshot    (snapCount),
                .overflow    (overflow)
            );

            assign liveWide[i]  = 64'(liveCount);
            assign snapWide[i]  = 64'(snapCount);
            assign enableVec[i] = enabled;
            assign ovfVec[i]    = overflow;
        end else begin : gIdle
            assign liveWide[i]  = '0;
            assign snapWide[i]  = '0;
            assign enableVec[i] = 1'b0;
            assign ovfVec[i]    = 1'b0;
        end
    end

    // Read mux over pre-edge state so reads combined with clear/snapshot return old values
    always_comb begin
        readData = '0;
        picked   = '0;
        if (bus.valueA[A_STATUS]) begin
            readData = packStatus(ovfVec, enableVec);
        end else begin
            picked   = bus.valueA[A_SNAPSHOT] ? snapWide[readIndex] : liveWide[readIndex];
            readData = bus.valueA[A_HIGH_WORD] ? picked[63:32] : picked[31:0];
        end
    end

    // One-cycle done pulse with result held at zero outside the pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done   <= accept;
            bus.result <= accept ? readData : 32'd0;
        end
    end

endmodule

// File: tb/tb_profile_counter_bank_ci.sv
// tb/tb_profile_counter_bank_ci.sv - scoreboard bench for the profiling counter bank
module tb_profile_counter_bank_ci;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    int          sel;
    logic [3:0]  evA, evB, evC;
    logic        started = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] qA[$], qB[$], qC[$];
    string       tA[$], tB[$], tC[$];

    always #5 clock = ~clock;

    profile_counter_bank_ci_if ifA();
    profile_counter_bank_ci_if ifB();
    profile_counter_bank_ci_if ifC();

    assign ifA.start = start && (sel == 0);
    assign ifB.start = start && (sel == 1);
    assign ifC.start = start && (sel == 2);
    assign ifA.ciN = ciN;    assign ifB.ciN = ciN;    assign ifC.ciN = ciN;
    assign ifA.valueA = valueA; assign ifB.valueA = valueA; assign ifC.valueA = valueA;
    assign ifA.valueB = valueB; assign ifB.valueB = valueB; assign ifC.valueB = valueB;

    profile_counter_bank_ci #(.CUSTOM_ID(8'h00), .NUM_COUNTERS(4), .COUNTER_WIDTH(32)) uA (
        .clock(clock), .reset(reset), .events(evA), .bus(ifA));
    profile_counter_bank_ci #(.CUSTOM_ID(8'h00), .NUM_COUNTERS(4), .COUNTER_WIDTH(8)) uB (
        .clock(clock), .reset(reset), .events(evB), .bus(ifB));
    profile_counter_bank_ci #(.CUSTOM_ID(8'h00), .NUM_COUNTERS(4), .COUNTER_WIDTH(64)) uC (
        .clock(clock), .reset(reset), .events(evC), .bus(ifC));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pops: every done must match one queued expectation, otherwise result must be zero
    always @(negedge clock) if (started) begin
        logic [31:0] e; string t;
        if (ifA.done) begin
            if (qA.size() == 0) check("A_done_unexpected", 64'(ifA.done), 64'd0);
            else begin e = qA.pop_front(); t = tA.pop_front(); check(t, 64'(ifA.result), 64'(e)); end
        end else check("A_idle_result", 64'(ifA.result), 64'd0);
    end

    always @(negedge clock) if (started) begin
        logic [31:0] e; string t;
        if (ifB.done) begin
            if (qB.size() == 0) check("B_done_unexpected", 64'(ifB.done), 64'd0);
            else begin e = qB.pop_front(); t = tB.pop_front(); check(t, 64'(ifB.result), 64'(e)); end
        end else check("B_idle_result", 64'(ifB.result), 64'd0);
    end

    always @(negedge clock) if (started) begin
        logic [31:0] e; string t;
        if (ifC.done) begin
            if (qC.size() == 0) check("C_done_unexpected", 64'(ifC.done), 64'd0);
            else begin e = qC.pop_front(); t = tC.pop_front(); check(t, 64'(ifC.result), 64'(e)); end
        end else check("C_idle_result", 64'(ifC.result), 64'd0);
    end

    task automatic cmd(input int k, input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
        sel    = k;
        ciN    = n;
        valueA = a;
        valueB = b;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
    endtask

    task automatic rd(input int k, input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
        case (k)
            0: begin qA.push_back(exp); tA.push_back(tag); end
            1: begin qB.push_back(exp); tB.push_back(tag); end
            default: begin qC.push_back(exp); tC.push_back(tag); end
        endcase
        cmd(k, 8'h00, a, b);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0; sel = 0;
        evA = '0; evB = '0; evC = '0;
        ticks(3);
        reset = 1'b0;
        started = 1'b1;

        // Reset state, back-to-back reads, foreign ciN ignored
        for (int i = 0; i < 4; i++) rd(0, $sformatf("A_reset_ctr%0d", i), 32'(i), 32'h0, 32'h0);
        rd(0, "A_reset_status", 32'h20, 32'h0, 32'h0);
        rd(1, "B_reset_status", 32'h20, 32'h0, 32'h0);
        rd(2, "C_reset_hi", 32'h08, 32'h0, 32'h0);
        cmd(0, 8'h05, 32'h0, 32'h1);
        ticks(1);
        rd(0, "A_foreign_ci_status", 32'h20, 32'h0, 32'h0);

        // Enable ctr0 with its event already high: counts start the edge after the command
        evA[0] = 1'b1;
        rd(0, "A_enable_ctr0", 32'h0, 32'h1, 32'h0);
        ticks(10);
        evA[0] = 1'b0;
        rd(0, "A_ctr0_10", 32'h0, 32'h0, 32'd10);
        rd(0, "A_status_en0", 32'h20, 32'h0, 32'h1);

        // Eight-bit wrap, sticky overflow, flag clear, wrap coinciding with flag clear
        rd(1, "B_enable_ctr1", 32'h1, 32'h2, 32'h0);
        evB[1] = 1'b1;
        ticks(300);
        evB[1] = 1'b0;
        rd(1, "B_ctr1_44", 32'h1, 32'h0, 32'd44);
        rd(1, "B_status_ovf", 32'h20, 32'h0, 32'h0202);
        rd(1, "B_clrovf_old_status", 32'h20, 32'h1 << 25, 32'h0202);
        rd(1, "B_status_cleared", 32'h20, 32'h0, 32'h0002);
        evB[1] = 1'b1;
        ticks(211);
        rd(1, "B_ctr1_255", 32'h1, 32'h1 << 25, 32'd255);
        evB[1] = 1'b0;
        rd(1, "B_status_set_wins", 32'h20, 32'h0, 32'h0202);
        rd(1, "B_ctr1_wrapped", 32'h1, 32'h0, 32'h0);

        // Snapshot with simultaneous read, then diverge live from snapshot
        rd(0, "A_enable_ctr2", 32'h2, 32'h4, 32'h0);
        evA[2] = 1'b1;
        ticks(1000);
        evA[2] = 1'b0;
        rd(0, "A_snap_read_ctr2", 32'h2, 32'h1 << 24, 32'd1000);
        evA[2] = 1'b1;
        ticks(50);
        evA[2] = 1'b0;
        rd(0, "A_snap_ctr2", 32'h12, 32'h0, 32'd1000);
        rd(0, "A_live_ctr2", 32'h2, 32'h0, 32'd1050);
        rd(0, "A_snap_ctr0", 32'h10, 32'h0, 32'd10);

        // Word selection and out-of-range index on the 32-bit bank
        rd(0, "A_hi_word_w32", 32'h8, 32'h0, 32'h0);
        rd(0, "A_index7_live", 32'h7, 32'h0, 32'h0);
        rd(0, "A_index7_snap", 32'h17, 32'h0, 32'h0);

        // 64-bit counter carried across the 32-bit boundary
        force uC.gCtr[0].gLive.uCounter.count = 64'h0000_0000_FFFF_FFFE;
        ticks(1);
        release uC.gCtr[0].gLive.uCounter.count;
        rd(2, "C_preload_lo", 32'h0, 32'h1, 32'hFFFF_FFFE);
        evC[0] = 1'b1;
        ticks(4);
        evC[0] = 1'b0;
        rd(2, "C_lo_after_carry", 32'h0, 32'h0, 32'h2);
        rd(2, "C_hi_after_carry", 32'h8, 32'h0, 32'h1);
        rd(2, "C_status", 32'h20, 32'h0, 32'h1);

        // Enable+disable same counter, clear with read, clear with enable
        rd(0, "A_en_dis_ctr3", 32'h3, (32'h1 << 3) | (32'h1 << 11), 32'h0);
        rd(0, "A_status_dis_wins", 32'h20, 32'h0, 32'h5);
        rd(0, "A_clear_read_old", 32'h2, 32'h1 << 18, 32'd1050);
        rd(0, "A_after_clear", 32'h2, 32'h0, 32'h0);
        evA[1] = 1'b1;
        rd(0, "A_clear_enable_ctr1", 32'h1, (32'h1 << 17) | 32'h2, 32'h0);
        ticks(5);
        evA[1] = 1'b0;
        rd(0, "A_ctr1_5", 32'h1, 32'h0, 32'd5);

        // Reset while counting and while a command is being accepted
        evA = 4'hF;
        ticks(5);
        sel = 0; ciN = 8'h00; valueA = 32'h0; valueB = 32'h1; start = 1'b1; reset = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        ticks(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) rd(0, $sformatf("A_post_reset_ctr%0d", i), 32'(i), 32'h0, 32'h0);
        rd(0, "A_post_reset_snap2", 32'h12, 32'h0, 32'h0);
        rd(0, "A_post_reset_status", 32'h20, 32'h0, 32'h0);
        evA = '0;
        rd(1, "B_post_reset_status", 32'h20, 32'h0, 32'h0);
        rd(2, "C_post_reset_lo", 32'h0, 32'h0, 32'h0);
        rd(2, "C_post_reset_hi", 32'h8, 32'h0, 32'h0);

        ticks(3);
        check("A_queue_drained", 64'(qA.size()), 64'd0);
        check("B_queue_drained", 64'(qB.size()), 64'd0);
        check("C_queue_drained", 64'(qC.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
